// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Parametrised register between two pipeline stages (F/D, D/E, E/M, M/W).
// It carries a PC, a generic payload, an exception code and a branch-delay
// flag. A one-entry skid buffer lets the stage absorb one extra slot while
// downstream backpressures. The stage also implements stall bubbles, flush
// and exception redirect.
//
// Handshake (valid/ready):
//   - A slot transfers on a clock edge when valid and ready are both high on
//     that interface.
//   - in_ready is combinational. It never depends on in_valid.
//   - While out_valid && !out_ready, every out_* field holds steady.
//   - req and flush ignore out_ready. They override whatever is held.
//
// Ports:
//   clk         clock; all state updates on posedge
//   reset       synchronous, active-low reset
//   in_valid    upstream slot valid
//   in_ready    stage accepts the upstream slot this cycle
//   in_pc       upstream PC
//   in_data     upstream payload
//   in_exc      upstream exception code
//   in_bd       upstream branch-delay flag
//   stall       hazard stall: insert a bubble, do not consume upstream
//   flush       squash main and skid contents
//   req         exception request: redirect to HANDLER_PC
//   out_valid   output slot valid
//   out_ready   downstream consumes the output slot
//   out_bubble  output slot is an inserted bubble (payload zero)
//   out_pc      registered PC
//   out_data    registered payload
//   out_exc     registered exception code
//   out_bd      registered branch-delay flag
//   bubble_cnt  saturating count of stall bubbles inserted
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
   parameter int              PC_W       = 32,
   parameter int              DATA_W     = 128,
   parameter int              EXC_W      = 5,
   parameter logic [PC_W-1:0] HANDLER_PC = 32'h0000_4180,
   parameter int              CNT_W      = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PC_W-1:0]   in_pc,
   input  logic [DATA_W-1:0] in_data,
   input  logic [EXC_W-1:0]  in_exc,
   input  logic              in_bd,
   input  logic              stall,
   input  logic              flush,
   input  logic              req,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_bubble,
   output logic [PC_W-1:0]   out_pc,
   output logic [DATA_W-1:0] out_data,
   output logic [EXC_W-1:0]  out_exc,
   output logic              out_bd,
   output logic [CNT_W-1:0]  bubble_cnt
);

   // Skid slot. It is only ever valid while the main slot is valid and
   // blocked downstream.
   logic              skid_valid;
   logic [PC_W-1:0]   skid_pc;
   logic [DATA_W-1:0] skid_data;
   logic [EXC_W-1:0]  skid_exc;
   logic              skid_bd;

   logic adv;     // main slot may be reloaded this cycle
   logic accept;  // upstream slot is consumed this cycle

   assign adv      = !out_valid || out_ready;
   assign in_ready = !skid_valid && !stall && !flush && !req;
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (!reset) begin
         out_valid  <= 1'b0;
         out_bubble <= 1'b0;
         out_pc     <= '0;
         out_data   <= '0;
         out_exc    <= '0;
         out_bd     <= 1'b0;
         skid_valid <= 1'b0;
         skid_pc    <= '0;
         skid_data  <= '0;
         skid_exc   <= '0;
         skid_bd    <= 1'b0;
         bubble_cnt <= '0;
      end else if (req) begin
         // Redirect to the handler. This is marked as a bubble so the
         // downstream stage does not execute it as a real instruction.
         out_valid  <= 1'b1;
         out_bubble <= 1'b1;
         out_pc     <= HANDLER_PC;
         out_data   <= '0;
         out_exc    <= '0;
         out_bd     <= 1'b0;
         skid_valid <= 1'b0;
         skid_pc    <= '0;
         skid_data  <= '0;
         skid_exc   <= '0;
         skid_bd    <= 1'b0;
      end else if (flush) begin
         out_valid  <= 1'b0;
         out_bubble <= 1'b0;
         out_pc     <= '0;
         out_data   <= '0;
         out_exc    <= '0;
         out_bd     <= 1'b0;
         skid_valid <= 1'b0;
         skid_pc    <= '0;
         skid_data  <= '0;
         skid_exc   <= '0;
         skid_bd    <= 1'b0;
      end else if (stall) begin
         if (adv && skid_valid) begin
            // The older buffered slot goes out ahead of any bubble.
            out_valid  <= 1'b1;
            out_bubble <= 1'b0;
            out_pc     <= skid_pc;
            out_data   <= skid_data;
            out_exc    <= skid_exc;
            out_bd     <= skid_bd;
            skid_valid <= 1'b0;
            skid_pc    <= '0;
            skid_data  <= '0;
            skid_exc   <= '0;
            skid_bd    <= 1'b0;
         end else if (adv) begin
            // The bubble keeps PC/exc/bd from upstream so that a later
            // exception can still be reported precisely against this slot.
            out_valid  <= 1'b1;
            out_bubble <= 1'b1;
            out_pc     <= in_pc;
            out_data   <= '0;
            out_exc    <= in_exc;
            out_bd     <= in_bd;
            if (bubble_cnt != {CNT_W{1'b1}})
               bubble_cnt <= bubble_cnt + 1'b1;
         end
      end else begin
         if (adv) begin
            if (skid_valid) begin
               // in_ready is low while skid_valid, so no refill can happen
               // in the same cycle.
               out_valid  <= 1'b1;
               out_bubble <= 1'b0;
               out_pc     <= skid_pc;
               out_data   <= skid_data;
               out_exc    <= skid_exc;
               out_bd     <= skid_bd;
               skid_valid <= 1'b0;
               skid_pc    <= '0;
               skid_data  <= '0;
               skid_exc   <= '0;
               skid_bd    <= 1'b0;
            end else if (accept) begin
               out_valid  <= 1'b1;
               out_bubble <= 1'b0;
               out_pc     <= in_pc;
               out_data   <= in_data;
               out_exc    <= in_exc;
               out_bd     <= in_bd;
            end else begin
               out_valid  <= 1'b0;
               out_bubble <= 1'b0;
               out_pc     <= '0;
               out_data   <= '0;
               out_exc    <= '0;
               out_bd     <= 1'b0;
            end
         end else if (accept) begin
            // Main slot is blocked downstream, so park the new slot.
            skid_valid <= 1'b1;
            skid_pc    <= in_pc;
            skid_data  <= in_data;
            skid_exc   <= in_exc;
            skid_bd    <= in_bd;
         end
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

   localparam int PC_W   = 32;
   localparam int DATA_W = 128;
   localparam int EXC_W  = 5;
   localparam int CNT_W  = 16;
   localparam logic [PC_W-1:0] HPC = 32'h0000_4180;
   // Slot image: {bubble, bd, exc, pc, data}
   localparam int SW = 1 + 1 + EXC_W + PC_W + DATA_W;

   logic              clk;
   logic              reset;
   logic              in_valid;
   logic              in_ready;
   logic [PC_W-1:0]   in_pc;
   logic [DATA_W-1:0] in_data;
   logic [EXC_W-1:0]  in_exc;
   logic              in_bd;
   logic              stall;
   logic              flush;
   logic              req;
   logic              out_valid;
   logic              out_ready;
   logic              out_bubble;
   logic [PC_W-1:0]   out_pc;
   logic [DATA_W-1:0] out_data;
   logic [EXC_W-1:0]  out_exc;
   logic              out_bd;
   logic [CNT_W-1:0]  bubble_cnt;

   pipe_stage_reg #(
      .PC_W(PC_W), .DATA_W(DATA_W), .EXC_W(EXC_W),
      .HANDLER_PC(HPC), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_data(in_data), .in_exc(in_exc), .in_bd(in_bd),
      .stall(stall), .flush(flush), .req(req),
      .out_valid(out_valid), .out_ready(out_ready), .out_bubble(out_bubble),
      .out_pc(out_pc), .out_data(out_data), .out_exc(out_exc), .out_bd(out_bd),
      .bubble_cnt(bubble_cnt)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   // The stage behaves as a FIFO of at most two slots (main + skid).
   // exp_q[0] is what must be on the output.
   logic [SW-1:0] exp_q[$];
   int            exp_cnt;
   int            checks;
   int            errors;

   task automatic check(input string tag, input logic [255:0] obs,
                        input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: check in_ready, advance the model, clock the DUT, check outputs.
   task automatic step();
      logic [SW-1:0] in_slot;
      logic [SW-1:0] front;
      logic          exp_ready;
      logic          acc;
      logic          can_adv;
      int            sz;
      in_slot   = {1'b0, in_bd, in_exc, in_pc, in_data};
      sz        = exp_q.size();
      exp_ready = (sz < 2) && !stall && !flush && !req;
      #1;
      if (reset) check("in_ready", in_ready, exp_ready);
      acc     = in_valid && exp_ready;
      can_adv = (sz == 0) || out_ready;
      if (!reset) begin
         exp_q.delete();
         exp_cnt = 0;
      end else if (req) begin
         exp_q.delete();
         exp_q.push_back({1'b1, 1'b0, {EXC_W{1'b0}}, HPC, {DATA_W{1'b0}}});
      end else if (flush) begin
         exp_q.delete();
      end else if (stall) begin
         if (can_adv) begin
            if (sz == 2) begin
               void'(exp_q.pop_front());
            end else begin
               exp_q.delete();
               exp_q.push_back({1'b1, in_bd, in_exc, in_pc, {DATA_W{1'b0}}});
               if (exp_cnt < 65535) exp_cnt++;
            end
         end
      end else begin
         if (can_adv && sz > 0) void'(exp_q.pop_front());
         if (acc) exp_q.push_back(in_slot);
      end
      @(posedge clk);
      #1;
      front = (exp_q.size() > 0) ? exp_q[0] : '0;
      check("out_valid",  out_valid,  exp_q.size() > 0);
      check("out_bubble", out_bubble, front[SW-1]);
      check("out_bd",     out_bd,     front[SW-2]);
      check("out_exc",    out_exc,    front[SW-3 -: EXC_W]);
      check("out_pc",     out_pc,     front[DATA_W +: PC_W]);
      check("out_data",   out_data,   front[DATA_W-1:0]);
      check("bubble_cnt", bubble_cnt, exp_cnt);
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive_slot(input logic v, input logic [PC_W-1:0] pc,
                             input logic [EXC_W-1:0] exc, input logic bd);
      in_valid = v;
      in_pc    = pc;
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      in_exc   = exc;
      in_bd    = bd;
   endtask

   task automatic drive_ctl(input logic st, input logic fl, input logic rq,
                            input logic ordy);
      stall     = st;
      flush     = fl;
      req       = rq;
      out_ready = ordy;
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      checks  = 0;
      errors  = 0;
      exp_cnt = 0;
      reset   = 1'b0;
      drive_ctl(1'b0, 1'b0, 1'b0, 1'b1);
      drive_slot(1'b1, 32'h3000, 5'd0, 1'b0);

      // Reset held 2 cycles with in_valid high
      step();
      step();
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_pc", out_pc, 32'h0);
      check("rst_bubble_cnt", bubble_cnt, 16'h0);

      // First slot after release: 1-cycle latency
      reset = 1'b1;
      step();
      check("first_pc", out_pc, 32'h3000);

      // Streaming at full rate
      drive_slot(1'b1, 32'h3004, 5'd0, 1'b0);
      step();
      check("stream_pc1", out_pc, 32'h3004);
      drive_slot(1'b1, 32'h3008, 5'd0, 1'b0);
      step();
      check("stream_pc2", out_pc, 32'h3008);
      check("stream_nobubble", out_bubble, 1'b0);

      // Backpressure: 0x3008 held, 0x300C goes to skid
      drive_ctl(1'b0, 1'b0, 1'b0, 1'b0);
      drive_slot(1'b1, 32'h300C, 5'd0, 1'b0);
      step();
      check("bp_hold_pc", out_pc, 32'h3008);
      #1 check("bp_in_ready_low", in_ready, 1'b0);
      drive_ctl(1'b0, 1'b0, 1'b0, 1'b1);
      drive_slot(1'b0, 32'h0, 5'd0, 1'b0);
      step();
      check("skid_drain_pc", out_pc, 32'h300C);
      step();
      check("drained_empty", out_valid, 1'b0);

      // Stall bubbles: 3 cycles
      drive_ctl(1'b1, 1'b0, 1'b0, 1'b1);
      drive_slot(1'b1, 32'h3010, 5'd4, 1'b1);
      repeat (3) step();
      check("bub_pc", out_pc, 32'h3010);
      check("bub_exc", out_exc, 5'd4);
      check("bub_flag", out_bubble, 1'b1);
      check("bub_cnt3", bubble_cnt, 16'd3);
      // Upstream was not consumed: it now goes through
      drive_ctl(1'b0, 1'b0, 1'b0, 1'b1);
      step();
      check("after_stall_pc", out_pc, 32'h3010);
      check("after_stall_nobub", out_bubble, 1'b0);

      // Fill main + skid, then req with stall and out_ready low
      drive_ctl(1'b0, 1'b0, 1'b0, 1'b0);
      drive_slot(1'b1, 32'h3020, 5'd1, 1'b0);
      step();
      drive_ctl(1'b1, 1'b0, 1'b1, 1'b0);
      drive_slot(1'b1, 32'h3024, 5'd2, 1'b1);
      step();
      check("req_pc", out_pc, HPC);
      check("req_valid", out_valid, 1'b1);
      check("req_bubble", out_bubble, 1'b1);
      drive_ctl(1'b0, 1'b0, 1'b0, 1'b0);
      #1 check("req_skid_empty", in_ready, 1'b1);

      // Flush with skid full
      drive_ctl(1'b0, 1'b0, 1'b0, 1'b0);
      drive_slot(1'b1, 32'h3030, 5'd0, 1'b0);
      step();
      drive_slot(1'b0, 32'h0, 5'd0, 1'b0);
      drive_ctl(1'b0, 1'b1, 1'b0, 1'b0);
      step();
      check("flush_valid", out_valid, 1'b0);
      check("flush_pc", out_pc, 32'h0);

      // Randomised traffic against the FIFO model
      for (int i = 0; i < 800; i++) begin
         reset = ($urandom_range(0, 149) != 0);
         drive_ctl($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0,
                   $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0);
         drive_slot($urandom_range(0, 3) != 0, $urandom, 5'($urandom_range(0, 31)),
                    1'($urandom_range(0, 1)));
         step();
      end

      // Saturation of the bubble counter under continuous stall
      reset = 1'b1;
      drive_ctl(1'b1, 1'b0, 1'b0, 1'b1);
      drive_slot(1'b0, 32'h3040, 5'd3, 1'b0);
      repeat (65535 - exp_cnt + 4) step();
      check("cnt_saturated", bubble_cnt, 16'hFFFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
